// File: rtl/ttl_74191_sync.sv
// 74LS191-style presettable up/down counter, single-clock model with Cen edge detect.
// Define TTL74191_RCO_REG_EN to register RCO_bar (one Clk lag, glitch-free for cascading).
module ttl_74191_sync #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Cen,
    input  logic             CTEN_bar,
    input  logic             D_U,
    input  logic             Load_bar,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             MAX_MIN,
    output logic             RCO_bar
);

    logic last_cen;
    logic cen_rise;
    logic rco_nom;

    assign cen_rise = Cen & ~last_cen;

    // last_cen resets high so a Cen held high across reset release is not a rising edge
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            last_cen <= 1'b1;
            Q        <= '0;
        end else begin
            last_cen <= Cen;
            if (!Load_bar)
                Q <= D;
            else if (cen_rise && !CTEN_bar)
                Q <= D_U ? Q - WIDTH'(1) : Q + WIDTH'(1);
        end
    end

    assign MAX_MIN = D_U ? (Q == '0) : (Q == '1);
    assign rco_nom = ~(~Cen & ~CTEN_bar & MAX_MIN);

`ifdef TTL74191_RCO_REG_EN
    logic rco_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            rco_q <= 1'b1;
        else
            rco_q <= rco_nom;
    end

    assign RCO_bar = rco_q;
`else
    assign RCO_bar = rco_nom;
`endif

endmodule

// File: tb/tb_ttl_74191_sync.sv
// Directed-vector bench for ttl_74191_sync (WIDTH=4), both RCO_bar build variants.
module tb_ttl_74191_sync;

    logic       Clk, Rst, Cen, CTEN_bar, D_U, Load_bar;
    logic [3:0] D, Q;
    logic       MAX_MIN, RCO_bar;

    int checks   = 0;
    int failures = 0;

    ttl_74191_sync #(.WIDTH(4)) dut (
        .Clk(Clk), .Rst(Rst), .Cen(Cen), .CTEN_bar(CTEN_bar), .D_U(D_U),
        .Load_bar(Load_bar), .D(D), .Q(Q), .MAX_MIN(MAX_MIN), .RCO_bar(RCO_bar)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       cen;
        logic       cten_bar;
        logic       d_u;
        logic       load_bar;
        logic [3:0] d;
        logic [3:0] q;
        logic       mm;
        logic       rco;   // combinational RCO_bar value after the edge
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic mm_of(input logic [3:0] q, input logic du);
        return du ? (q == 4'h0) : (q == 4'hF);
    endfunction

    initial begin
        logic [3:0] q_prev;
        logic       rco_pre, exp_rco;

        // cen cten du ld   d     q     mm    rco
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,4'hE, 4'hE,1'b0,1'b1}); // load E
        vecs.push_back('{1'b1,1'b0,1'b0,1'b1,4'h0, 4'hF,1'b1,1'b1}); // up -> F
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,4'h0, 4'hF,1'b1,1'b0}); // RCO low phase
        vecs.push_back('{1'b1,1'b0,1'b0,1'b1,4'h0, 4'h0,1'b0,1'b1}); // wrap up -> 0
        vecs.push_back('{1'b0,1'b0,1'b1,1'b0,4'h1, 4'h1,1'b0,1'b1}); // load 1, down
        vecs.push_back('{1'b1,1'b0,1'b1,1'b1,4'h0, 4'h0,1'b1,1'b1}); // down -> 0
        vecs.push_back('{1'b0,1'b0,1'b1,1'b1,4'h0, 4'h0,1'b1,1'b0}); // RCO low at min
        vecs.push_back('{1'b1,1'b0,1'b1,1'b1,4'h0, 4'hF,1'b0,1'b1}); // wrap down -> F
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,4'h0, 4'hF,1'b1,1'b0}); // dir up at F
        vecs.push_back('{1'b1,1'b0,1'b0,1'b0,4'h5, 4'h5,1'b0,1'b1}); // load wins over rise
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,4'h0, 4'h5,1'b0,1'b1});
        vecs.push_back('{1'b1,1'b0,1'b0,1'b1,4'h0, 4'h6,1'b0,1'b1}); // up -> 6
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,4'hF, 4'hF,1'b1,1'b1}); // load F, disabled
        for (int i = 0; i < 4; i++) begin                          // 4 pulses, CTEN_bar=1
            vecs.push_back('{1'b1,1'b1,1'b0,1'b1,4'h0, 4'hF,1'b1,1'b1});
            vecs.push_back('{1'b0,1'b1,1'b0,1'b1,4'h0, 4'hF,1'b1,1'b1});
        end
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,4'h0, 4'h0,1'b0,1'b1}); // load 0

        // Reset with Cen held high, then release: no count
        Rst = 1'b1; Cen = 1'b1; CTEN_bar = 1'b0; D_U = 1'b0; Load_bar = 1'b1; D = 4'h0;
        step(); step();
        check("reset_q", Q, 4'h0);
        check("reset_mm", MAX_MIN, 1'b0);
        check("reset_rco", RCO_bar, 1'b1);
        Rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("no_count_after_reset", Q, 4'h0);
        end

        // Table vectors
        q_prev = 4'h0;
        foreach (vecs[i]) begin
            Cen = vecs[i].cen; CTEN_bar = vecs[i].cten_bar; D_U = vecs[i].d_u;
            Load_bar = vecs[i].load_bar; D = vecs[i].d;
            rco_pre = ~(~vecs[i].cen & ~vecs[i].cten_bar & mm_of(q_prev, vecs[i].d_u));
`ifdef TTL74191_RCO_REG_EN
            exp_rco = rco_pre;
`else
            exp_rco = vecs[i].rco;
`endif
            step();
            check($sformatf("vec%0d_q", i), Q, vecs[i].q);
            check($sformatf("vec%0d_mm", i), MAX_MIN, vecs[i].mm);
            check($sformatf("vec%0d_rco", i), RCO_bar, exp_rco);
            q_prev = vecs[i].q;
        end

        // D_U toggle at Q=0: MAX_MIN follows with no clock
        @(negedge Clk);
        D_U = 1'b1; #1;
        check("dir_toggle_mm_down", MAX_MIN, 1'b1);
        D_U = 1'b0; #1;
        check("dir_toggle_mm_up", MAX_MIN, 1'b0);

        // Count 8 -> 9, then asynchronous reset mid-cycle
        step();
        Load_bar = 1'b0; D = 4'h8; CTEN_bar = 1'b0; Cen = 1'b0;
        step();
        Load_bar = 1'b1;
        step();
        check("pre_rst_q8", Q, 4'h8);
        Cen = 1'b1;
        step();
        check("pre_rst_q9", Q, 4'h9);
        #2 Rst = 1'b1;
        #1;
        check("async_rst_q", Q, 4'h0);
        check("async_rst_rco", RCO_bar, 1'b1);
        check("async_rst_mm", MAX_MIN, 1'b0);
        step();
        Rst = 1'b0;
        step();
        check("post_rst_hold", Q, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
